rc4_key_search: RTL
===================

# rc4_key_search

Parametrised RC4 brute-force key-search engine. It iterates candidate keys over a programmable range [key_lo, key_hi] and, for each key, runs the sequence below:
- fill S with 0..255;
- run the key-scheduling swap loop;
- decrypt MSG_LEN ciphertext bytes from an external ROM, rejecting the key on the first byte outside the selected character set.

Several instances with disjoint ranges form a multi-core cracker. Each instance owns one external S RAM, one ciphertext ROM and one plaintext RAM.

## Interface
- KEY_BYTES, 3: key length in bytes; key byte 0 is the most-significant byte.
- MSG_LEN, 32: message length in bytes, 1..256.
- PT_AW, 5: plaintext/ROM address width, at least clog2(MSG_LEN).
- CHARSET, 0: acceptance set. 0 = 'a'..'z' or 0x20. 1 = 0x20..0x7E.
- CLOCK_50  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  synchronous; ends any search.
- key_lo, key_hi  in  8*KEY_BYTES  inclusive search range, sampled on start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  level; set at search end, cleared by the next accepted start.
- found  out  1  valid while done=1.
- key_out  out  8*KEY_BYTES  current candidate; after done, the found key or the last key tried.
- s_addr, s_wdata  out  8  S RAM address/data; s_we out 1.
- s_q  in  8  S RAM read data.
- rom_addr  out  PT_AW; rom_q  in  8  ciphertext.
- pt_addr  out  PT_AW; pt_data  out  8; pt_we  out  1  plaintext write port.

## Operation
- **Memory latency.** All outputs are registered. Memory q reflects the address registered at the previous edge, so every read needs one wait state.
- **Reset.** All outputs are 0 and state is IDLE.
- **Start.**
  - On start in IDLE: latch key_lo/key_hi, set key_out=key_lo, clear done/found, set busy, go to FILL.
  - If key_lo > key_hi: go straight to FIN with found=0 and key_out=key_lo.
- **FILL.** s_we=1 and s_addr=s_wdata=n for n=0..255, one write per cycle.
- **Key schedule**, for i=0..255:
  - KS_RD_I: s_addr=i. KS_WT_I: wait.
  - KS_RD_J: j=(j+s_q+key[i mod KEY_BYTES]) mod 256, s_addr=j. KS_WT_J: wait.
  - KS_WR_I: write S[j] to i. KS_WR_J: write S[i] to j.
  - i wraps 255 -> 0 and the block proceeds to PRGA with i=j=0.
- **PRGA**, for k=0..MSG_LEN-1:
  - PR_RD_I: i=i+1, s_addr=i. PR_WT_I: wait.
  - PR_RD_J: j=j+S[i], s_addr=j. PR_WT_J: wait.
  - PR_WR_I, PR_WR_J: swap.
  - PR_RD_F: s_addr=(S[i]+S[j]) mod 256, rom_addr=k. PR_WT_F: wait.
  - PR_CHK: p = s_q XOR rom_q, then:
    - p outside CHARSET: go to NEXT_KEY with no write.
    - otherwise: pt_we=1, pt_addr=k, pt_data=p. If k=MSG_LEN-1, found=1 and go to FIN; else continue with k+1.
- **NEXT_KEY.** If key_out==key_hi, found=0 and go to FIN. Otherwise key_out+1 and go to FILL. key_out never wraps, including when key_hi is all ones.
- **FIN.** done=1, busy=0, go to IDLE. key_out is held.
- **abort.** In any non-IDLE state: next edge gives FIN with found=0 and s_we=pt_we=0. abort in IDLE is ignored.
- **start while busy.** Ignored.
- **Plaintext RAM.** Contents are meaningful only when found=1. Partial writes from rejected keys may remain.
- **Reset mid-operation.** Immediate IDLE, outputs 0. Memory contents are don't-care.

## Timing
- FILL: 256 cycles.
- KSA: 6 cycles per i, 1536 total.
- PRGA: 9 cycles per byte.
- Full accepted key from the FILL entry to found: 256+1536+9*MSG_LEN cycles, which is 2080 for MSG_LEN=32.
- Rejected key at byte index r: 256+1536+9*(r+1)+1 cycles, the +1 being NEXT_KEY.
- busy rises 1 cycle after start. done rises 1 cycle after the PR_CHK or NEXT_KEY decision.
- s_we is 0 in every read and wait state. pt_we is a single-cycle pulse per accepted byte.

## Test plan
- ROM holds 32-byte ciphertext of "the quick brown fox jumps over t" under key 0x000123; key_lo=0, key_hi=0x0003FF, start -> done=1, found=1, key_out=0x000123, plaintext RAM matches byte-for-byte, and the cycle count from start to done matches the formula.
- Same ROM, range 0x000200..0x0002FF -> done=1, found=0, key_out=0x0002FF, with no 32nd pt_we.
- key_lo=0x000010, key_hi=0x00000F -> done 2 cycles after start, found=0, key_out=0x000010, and no s_we ever.
- Ciphertext under key 0xFFFFFF, range 0xFFFFFE..0xFFFFFF -> found=1, key_out=0xFFFFFF. Repeat with a non-matching ROM -> found=0, key_out=0xFFFFFF, and no wrap to 0.
- CHARSET=1, plaintext "Hello, World! RC4 test 0123 ok.." under key 0x00ABCD -> found=1. The same stimulus with CHARSET=0 -> key 0x00ABCD rejected at byte 0 ('H').
- reset asserted mid-KSA, then released -> all outputs 0 and IDLE. A new start completes correctly. abort asserted in PRGA -> done=1, found=0 on the next edge, and a start pulse issued while busy=1 is ignored.

Source files
------------

// File: rtl/rc4_key_search.sv
// RC4 brute-force key-search core: per candidate key it fills S,
// runs the key schedule and decrypts until a byte leaves the charset.
module rc4_key_search #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int PT_AW     = 5,
  parameter int CHARSET   = 0
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*KEY_BYTES-1:0] key_lo,
  input  logic [8*KEY_BYTES-1:0] key_hi,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [8*KEY_BYTES-1:0] key_out,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wdata,
  output logic                   s_we,
  input  logic [7:0]             s_q,
  output logic [PT_AW-1:0]       rom_addr,
  input  logic [7:0]             rom_q,
  output logic [PT_AW-1:0]       pt_addr,
  output logic [7:0]             pt_data,
  output logic                   pt_we
);

  localparam int KW  = 8 * KEY_BYTES;
  localparam int KBW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [7:0]     LAST    = 8'(MSG_LEN - 1);
  localparam logic [KBW-1:0] KB_LAST = KBW'(KEY_BYTES - 1);

  typedef enum logic [4:0] {
    IDLE, FILL,
    KS_RD_I, KS_WT_I, KS_RD_J, KS_WT_J, KS_WR_I, KS_WR_J,
    PR_RD_I, PR_WT_I, PR_RD_J, PR_WT_J, PR_WR_I, PR_WR_J,
    PR_RD_F, PR_WT_F, PR_CHK,
    NEXT_KEY, FIN
  } state_t;

  state_t         state;
  logic [KW-1:0]  hi_q;
  logic [7:0]     i, j, k, si, sj;
  logic [KBW-1:0] kb;
  logic [7:0]     kbyte;
  logic [7:0]     p;
  logic           p_ok;

  // key byte 0 sits in the most-significant position
  always_comb begin
    kbyte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kb == KBW'(b)) kbyte = key_out[KW-1-8*b -: 8];
    end
  end

  assign p = s_q ^ rom_q;

  always_comb begin
    if (CHARSET == 0) p_ok = (p >= 8'h61 && p <= 8'h7a) || p == 8'h20;
    else              p_ok = p >= 8'h20 && p <= 8'h7e;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      key_out  <= '0;
      hi_q     <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_we     <= 1'b0;
      rom_addr <= '0;
      pt_addr  <= '0;
      pt_data  <= '0;
      pt_we    <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      kb       <= '0;
    end else begin
      pt_we <= 1'b0;
      if (abort && state != IDLE && state != FIN) begin
        state <= FIN;
        found <= 1'b0;
        s_we  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            hi_q    <= key_hi;
            key_out <= key_lo;
            done    <= 1'b0;
            found   <= 1'b0;
            busy    <= 1'b1;
            if (key_lo > key_hi) begin
              state <= FIN;
            end else begin
              state   <= FILL;
              i       <= '0;
              s_addr  <= '0;
              s_wdata <= '0;
              s_we    <= 1'b1;
            end
          end
          FILL: if (i == 8'hff) begin
            state  <= KS_RD_I;
            i      <= '0;
            j      <= '0;
            kb     <= '0;
            s_addr <= '0;
            s_we   <= 1'b0;
          end else begin
            i       <= i + 8'd1;
            s_addr  <= i + 8'd1;
            s_wdata <= i + 8'd1;
          end
          KS_RD_I: state <= KS_WT_I;
          KS_WT_I: begin
            state  <= KS_RD_J;
            j      <= j + s_q + kbyte;
            s_addr <= j + s_q + kbyte;
            si     <= s_q;
          end
          KS_RD_J: state <= KS_WT_J;
          KS_WT_J: begin
            state   <= KS_WR_I;
            s_addr  <= i;
            s_wdata <= s_q;
            s_we    <= 1'b1;
          end
          KS_WR_I: begin
            state   <= KS_WR_J;
            s_addr  <= j;
            s_wdata <= si;
          end
          KS_WR_J: begin
            s_we <= 1'b0;
            kb   <= (kb == KB_LAST) ? '0 : kb + 1'b1;
            if (i == 8'hff) begin
              state  <= PR_RD_I;
              i      <= 8'd1;
              j      <= '0;
              k      <= '0;
              s_addr <= 8'd1;
            end else begin
              state  <= KS_RD_I;
              i      <= i + 8'd1;
              s_addr <= i + 8'd1;
            end
          end
          PR_RD_I: state <= PR_WT_I;
          PR_WT_I: begin
            state  <= PR_RD_J;
            j      <= j + s_q;
            s_addr <= j + s_q;
            si     <= s_q;
          end
          PR_RD_J: state <= PR_WT_J;
          PR_WT_J: begin
            state   <= PR_WR_I;
            s_addr  <= i;
            s_wdata <= s_q;
            s_we    <= 1'b1;
            sj      <= s_q;
          end
          PR_WR_I: begin
            state   <= PR_WR_J;
            s_addr  <= j;
            s_wdata <= si;
          end
          PR_WR_J: begin
            state    <= PR_RD_F;
            s_we     <= 1'b0;
            s_addr   <= si + sj;
            rom_addr <= k[PT_AW-1:0];
          end
          PR_RD_F: state <= PR_WT_F;
          PR_WT_F: state <= PR_CHK;
          PR_CHK: if (!p_ok) begin
            state <= NEXT_KEY;
          end else begin
            pt_we   <= 1'b1;
            pt_addr <= k[PT_AW-1:0];
            pt_data <= p;
            if (k == LAST) begin
              found <= 1'b1;
              state <= FIN;
            end else begin
              state  <= PR_RD_I;
              k      <= k + 8'd1;
              i      <= i + 8'd1;
              s_addr <= i + 8'd1;
            end
          end
          // compare before increment so key_out never wraps
          NEXT_KEY: if (key_out == hi_q) begin
            found <= 1'b0;
            state <= FIN;
          end else begin
            key_out <= key_out + 1'b1;
            state   <= FILL;
            i       <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_we    <= 1'b1;
          end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
